// File: rtl/fifo_pkg.sv
// fifo_pkg: shared constants for the synchronous FIFO slice.
//   FWFT_STD / FWFT_FALL : read-mode selectors for sync_fifo_fwft.FWFT
//   DEF_DATASIZE         : default data word width
//   DEF_ADDRSIZE         : default address width (depth = 2**ADDRSIZE)
package fifo_pkg;
  localparam int FWFT_STD     = 0;
  localparam int FWFT_FALL    = 1;
  localparam int DEF_DATASIZE = 8;
  localparam int DEF_ADDRSIZE = 4;
endpackage

// File: rtl/sync_fifo_mem.sv
// sync_fifo_mem: 2**ADDRSIZE x DATASIZE storage array.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (asynchronous read)
//   rdata : word at raddr
// Contents are deliberately not reset.
module sync_fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATASIZE = DEF_DATASIZE,
  parameter int ADDRSIZE = DEF_ADDRSIZE
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDRSIZE-1:0] waddr,
  input  logic [DATASIZE-1:0] wdata,
  input  logic [ADDRSIZE-1:0] raddr,
  output logic [DATASIZE-1:0] rdata
);
  logic [DATASIZE-1:0] mem [2**ADDRSIZE];

  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;

  assign rdata = mem[raddr];
endmodule

// File: rtl/sync_fifo_fwft.sv
// sync_fifo_fwft: single-clock FIFO with selectable standard / first-word-
// fall-through read behaviour, occupancy count and sticky error flags.
//   clk, rst      : clock, synchronous active-high reset
//   winc, wdata   : write request and data
//   rinc          : read request
//   clr_err       : clears overflow/underflow
//   rdata         : read data (registered when FWFT=0, head word when FWFT=1)
//   wfull, rempty : full / empty
//   walmost_full  : count >= AFULL_LVL
//   ralmost_empty : count <= AEMPTY_LVL
//   count         : occupancy 0..2**ADDRSIZE
//   overflow      : sticky, write rejected while full
//   underflow     : sticky, read attempted while empty
module sync_fifo_fwft
  import fifo_pkg::*;
#(
  parameter int DATASIZE   = DEF_DATASIZE,
  parameter int ADDRSIZE   = DEF_ADDRSIZE,
  parameter int AFULL_LVL  = 2**ADDRSIZE-2,
  parameter int AEMPTY_LVL = 2,
  parameter int FWFT       = FWFT_STD
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                winc,
  input  logic [DATASIZE-1:0] wdata,
  input  logic                rinc,
  input  logic                clr_err,
  output logic [DATASIZE-1:0] rdata,
  output logic                wfull,
  output logic                rempty,
  output logic                walmost_full,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   count,
  output logic                overflow,
  output logic                underflow
);
  localparam logic [ADDRSIZE:0] ONE      = {{ADDRSIZE{1'b0}}, 1'b1};
  localparam logic [ADDRSIZE:0] DEPTH_C  = {1'b1, {ADDRSIZE{1'b0}}};
  localparam logic [ADDRSIZE:0] AFULL_C  = AFULL_LVL[ADDRSIZE:0];
  localparam logic [ADDRSIZE:0] AEMPTY_C = AEMPTY_LVL[ADDRSIZE:0];

  logic [ADDRSIZE:0]   wptr, rptr, wptr_nxt, rptr_nxt, count_nxt;
  logic                rd_acc, wr_acc;
  logic [DATASIZE-1:0] head;

  assign rd_acc = rinc & ~rempty;
  // A write at full still goes in when a read frees the head slot this cycle.
  assign wr_acc = winc & (~wfull | rd_acc);

  assign wptr_nxt  = wr_acc ? wptr + ONE : wptr;
  assign rptr_nxt  = rd_acc ? rptr + ONE : rptr;
  // Extra pointer bit makes the difference the true occupancy, full included.
  assign count_nxt = wptr_nxt - rptr_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
      wfull         <= 1'b0;
      rempty        <= 1'b1;
      walmost_full  <= 1'b0;
      ralmost_empty <= 1'b1;
      overflow      <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      wptr          <= wptr_nxt;
      rptr          <= rptr_nxt;
      count         <= count_nxt;
      wfull         <= (count_nxt == DEPTH_C);
      rempty        <= (count_nxt == '0);
      walmost_full  <= (count_nxt >= AFULL_C);
      ralmost_empty <= (count_nxt <= AEMPTY_C);
      // New error wins over a same-cycle clear.
      overflow      <= (winc & ~wr_acc) | (overflow & ~clr_err);
      underflow     <= (rinc & rempty) | (underflow & ~clr_err);
    end
  end

  sync_fifo_mem #(.DATASIZE(DATASIZE), .ADDRSIZE(ADDRSIZE)) u_mem (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr[ADDRSIZE-1:0]),
    .wdata (wdata),
    .raddr (rptr[ADDRSIZE-1:0]),
    .rdata (head)
  );

  generate
    if (FWFT == FWFT_FALL) begin : g_fwft
      // Head word is visible as soon as the FIFO is non-empty.
      assign rdata = rempty ? '0 : head;
    end else begin : g_std
      // Captures the head before the same-edge write can touch that slot.
      always_ff @(posedge clk)
        if (rst)         rdata <= '0;
        else if (rd_acc) rdata <= head;
    end
  endgenerate
endmodule

// File: tb/tb_sync_fifo_fwft.sv
module tb_sync_fifo_fwft;
  logic       clk = 1'b0;
  logic       rst = 1'b1, winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
  logic [7:0] wdata = '0;

  logic [7:0] rdata0, rdata1;
  logic       wfull0, rempty0, af0, ae0, ovf0, udf0;
  logic       wfull1, rempty1, af1, ae1, ovf1, udf1;
  logic [4:0] count0, count1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_fwft #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(0)) d0 (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
    .rdata(rdata0), .wfull(wfull0), .rempty(rempty0), .walmost_full(af0),
    .ralmost_empty(ae0), .count(count0), .overflow(ovf0), .underflow(udf0));

  sync_fifo_fwft #(.DATASIZE(8), .ADDRSIZE(4), .FWFT(1)) d1 (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
    .rdata(rdata1), .wfull(wfull1), .rempty(rempty1), .walmost_full(af1),
    .ralmost_empty(ae1), .count(count1), .overflow(ovf1), .underflow(udf1));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words plus the sticky flags.
  logic [7:0] mq[$];
  bit         m_ovf = 0, m_udf = 0, chk_en = 0;
  logic [7:0] m_rd = '0;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_ovf = 0; m_udf = 0; m_rd = '0; chk_en = 1;
    end else begin
      bit empty, full, rd_ok, wr_ok;
      empty = (mq.size() == 0);
      full  = (mq.size() == 16);
      rd_ok = rinc && !empty;
      wr_ok = winc && (!full || rd_ok);
      m_ovf = (winc && !wr_ok) || (m_ovf && !clr_err);
      m_udf = (rinc && empty) || (m_udf && !clr_err);
      if (rd_ok) m_rd = mq.pop_front();
      if (wr_ok) mq.push_back(wdata);
    end
  end

  task automatic cmp(input string tg, input logic [7:0] rd, input logic wf, input logic re,
                     input logic af, input logic ae, input logic [4:0] cnt,
                     input logic ov, input logic ud, input logic [7:0] exp_rd);
    int n;
    n = mq.size();
    check({tg, ".count"}, cnt, n);
    check({tg, ".wfull"}, wf, (n == 16));
    check({tg, ".rempty"}, re, (n == 0));
    check({tg, ".walmost_full"}, af, (n >= 14));
    check({tg, ".ralmost_empty"}, ae, (n <= 2));
    check({tg, ".overflow"}, ov, m_ovf);
    check({tg, ".underflow"}, ud, m_udf);
    check({tg, ".rdata"}, rd, exp_rd);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("std", rdata0, wfull0, rempty0, af0, ae0, count0, ovf0, udf0, m_rd);
      cmp("fwft", rdata1, wfull1, rempty1, af1, ae1, count1, ovf1, udf1,
          (mq.size() != 0) ? mq[0] : 8'h00);
    end
  end

  task automatic step(input bit w, input logic [7:0] d, input bit r, input bit c, input bit rs);
    winc = w; wdata = d; rinc = r; clr_err = c; rst = rs;
    @(posedge clk);
    #1;
    winc = 0; rinc = 0; clr_err = 0; rst = 0;
  endtask

  initial begin
    // Reset
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    check("rst.count", count0, 0);
    check("rst.rempty", rempty0, 1);
    check("rst.ralmost_empty", ae0, 1);
    check("rst.rdata_std", rdata0, 0);
    check("rst.rdata_fwft", rdata1, 0);

    // Fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      step(1, 8'(i), 0, 0, 0);
      if (i == 12) check("fill.af_at13", af0, 0);
      if (i == 13) check("fill.af_at14", af0, 1);
    end
    check("fill.wfull", wfull0, 1);
    check("fill.count", count0, 16);
    step(1, 8'hEE, 0, 0, 0);
    check("fill.overflow", ovf0, 1);
    check("fill.count17", count0, 16);

    // Drain: standard mode shows each word one cycle after rinc
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 1, 0, 0);
      check("drain.rdata_std", rdata0, i);
    end
    check("drain.rempty", rempty0, 1);
    step(0, 0, 1, 0, 0);
    check("drain.underflow", udf0, 1);
    // Clear with a concurrent new underflow: underflow stays, overflow clears
    step(0, 0, 1, 1, 0);
    check("clr.udf_kept", udf0, 1);
    check("clr.ovf_cleared", ovf0, 0);
    step(0, 0, 0, 1, 0);
    check("clr.udf_cleared", udf0, 0);

    // Full with simultaneous read/write for 20 cycles
    for (int i = 0; i < 16; i++) step(1, 8'h80 + 8'(i), 0, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 8'h40 + 8'(i), 1, 0, 0);
    check("fullrw.wfull", wfull0, 1);
    check("fullrw.count", count0, 16);
    check("fullrw.overflow", ovf0, 0);
    check("fullrw.head_fwft", rdata1, 8'h44);
    step(0, 0, 1, 0, 0);
    check("fullrw.first_std", rdata0, 8'h44);
    for (int i = 0; i < 15; i++) step(0, 0, 1, 0, 0);
    check("fullrw.last_std", rdata0, 8'h53);

    // Simultaneous read/write at empty
    step(1, 8'h11, 1, 0, 0);
    check("rwempty.underflow", udf0, 1);
    check("rwempty.count", count0, 1);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);

    // FWFT single word
    step(1, 8'hA5, 0, 0, 0);
    check("fwft.rdata", rdata1, 8'hA5);
    check("fwft.rempty", rempty1, 0);
    step(0, 0, 1, 0, 0);
    check("fwft.rempty_after", rempty1, 1);

    // Wrap: interleaved write/read with random data
    for (int i = 0; i < 40; i++) begin
      step(1, 8'($urandom_range(0, 255)), 0, 0, 0);
      step(0, 0, 1, 0, 0);
    end

    // Reset mid-operation
    for (int i = 0; i < 9; i++) step(1, 8'h90 + 8'(i), 0, 0, 0);
    check("midrst.count_before", count0, 9);
    step(1, 8'hFF, 1, 1, 1);
    check("midrst.count", count0, 0);
    check("midrst.rempty", rempty0, 1);
    check("midrst.af", af0, 0);
    check("midrst.ovf", ovf0, 0);
    check("midrst.udf", udf0, 0);
    step(1, 8'h3C, 0, 0, 0);
    check("midrst.fwft_rdata", rdata1, 8'h3C);
    step(0, 0, 1, 0, 0);
    check("midrst.std_rdata", rdata0, 8'h3C);
    step(0, 0, 0, 0, 0);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sync_fifo_fwft.md
SYNC_FIFO_FWFT -- requirements
Module: sync_fifo_fwft

Interface
REQ-001 The block SHALL have parameter DATASIZE, default 8, data word width.
REQ-002 The block SHALL have parameter ADDRSIZE, default 4, depth = 2**ADDRSIZE.
REQ-003 The block SHALL have parameter AFULL_LVL, default 2**ADDRSIZE-2, almost-full threshold.
REQ-004 The block SHALL have parameter AEMPTY_LVL, default 2, almost-empty threshold.
REQ-005 The block SHALL have parameter FWFT, default 0: 0 = standard read, 1 = first-word-fall-through.
REQ-006 The block SHALL have port clk, input, 1, the only clock; all logic on rising edge.
REQ-007 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-008 The block SHALL have port winc, input, 1, write request.
REQ-009 The block SHALL have port wdata, input, DATASIZE, write data.
REQ-010 The block SHALL have port rinc, input, 1, read request.
REQ-011 The block SHALL have port clr_err, input, 1, clears sticky error flags.
REQ-012 The block SHALL have port rdata, output, DATASIZE, read data.
REQ-013 The block SHALL have port wfull, output, 1, FIFO full.
REQ-014 The block SHALL have port rempty, output, 1, no readable data.
REQ-015 The block SHALL have port walmost_full, output, 1, asserted when count >= AFULL_LVL.
REQ-016 The block SHALL have port ralmost_empty, output, 1, asserted when count <= AEMPTY_LVL.
REQ-017 The block SHALL have port count, output, ADDRSIZE+1, current occupancy, 0..2**ADDRSIZE.
REQ-018 The block SHALL have port overflow, output, 1, sticky: write attempted while full and not accepted.
REQ-019 The block SHALL have port underflow, output, 1, sticky: read attempted while rempty.

Function
REQ-020 Write and read pointers SHALL be ADDRSIZE+1 bits binary, wrapping modulo 2**(ADDRSIZE+1); memory address = low ADDRSIZE bits.
REQ-021 Write SHALL be accepted when winc & (!wfull | (rinc & !rempty)); accepted write stores wdata at waddr and increments wptr.
REQ-022 Read SHALL be accepted when rinc & !rempty; accepted read increments rptr.
REQ-023 count SHALL be registered: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-024 wfull, rempty, walmost_full, ralmost_empty SHALL be registered and reflect post-update count in the same cycle count updates.
REQ-025 FWFT=0: rdata SHALL be registered, updating one cycle after an accepted read with the head word; otherwise it holds.
REQ-026 FWFT=0: a word written into an empty FIFO SHALL clear rempty the cycle after the write.
REQ-027 FWFT=1: rdata SHALL present the head word whenever rempty=0 with no rinc needed; an accepted read advances rdata to the next word the following cycle.
REQ-028 FWFT=1: a word written into an empty FIFO SHALL appear on rdata with rempty=0 the cycle after the write.
REQ-029 Simultaneous read and write at full SHALL both be accepted; wfull stays 1 and count stays 2**ADDRSIZE.
REQ-030 Simultaneous read and write at empty: write SHALL be accepted, read SHALL be ignored and SHALL set underflow.
REQ-031 Rejected write SHALL set overflow; memory and wptr SHALL be unchanged.
REQ-032 clr_err SHALL clear overflow and underflow the next cycle; a same-cycle new error SHALL take priority (flag stays 1).

Reset
REQ-033 On rst=1 at a clock edge: pointers=0, count=0, rempty=1, wfull=0, ralmost_empty=1, walmost_full=0, overflow=0, underflow=0, rdata=0.
REQ-034 rst SHALL override all concurrent winc/rinc/clr_err; memory contents need not be cleared.
REQ-035 Reset mid-operation SHALL discard all stored words; the first post-reset write SHALL be the next word read.

Structure
REQ-036 A shared package fifo_pkg SHALL hold the FWFT mode constants and default DATASIZE/ADDRSIZE values.
REQ-037 Storage SHALL be one sub-module sync_fifo_mem: 2**ADDRSIZE x DATASIZE, one synchronous write port, one asynchronous read port.
REQ-038 Pointer, count, flag and rdata logic SHALL live in sync_fifo_fwft; no clock-domain crossing logic.

Verification (DATASIZE=8, ADDRSIZE=4)
REQ-039 Fill: 16 writes 0x00..0x0F -> wfull=1 after 16th, count=16, walmost_full=1 from count 14; 17th write -> overflow=1, contents unchanged.
REQ-040 Drain FWFT=0: 16 reads -> rdata 0x00..0x0F each one cycle after rinc, rempty=1 after last; extra read -> underflow=1.
REQ-041 FWFT=1: single write 0xA5 to empty -> next cycle rdata=0xA5, rempty=0 with no rinc; one read -> rempty=1.
REQ-042 Full with winc&rinc for 20 cycles -> wfull=1, count=16, output order preserved, overflow=0.
REQ-043 Wrap: 40 interleaved write/read pairs with random data -> scoreboard match, pointer wrap past 31 clean.
REQ-044 rst asserted with count=9 -> next cycle count=0, rempty=1, flags 0; write 0x3C then read -> 0x3C.
